// File: rtl/sdram_responder.sv
// SDRAM device responder: decodes controller commands, tracks init sequence and
// bank state, and models a 256x16 aliased storage array with CAS-latency read return.
//
// state     | meaning
// WAIT_PRE  | waiting for PRECHARGE ALL
// WAIT_REF  | waiting for two AUTO REFRESH commands
// WAIT_MODE | waiting for a valid LOAD MODE
// READY     | initialized, normal operation
module sdram_responder (
    input  logic        iclk,
    input  logic        ireset,
    input  logic [12:0] DRAM_ADDR,
    input  logic [1:0]  DRAM_BA,
    input  logic        DRAM_CKE,
    input  logic        DRAM_CS_N,
    input  logic        DRAM_RAS_N,
    input  logic        DRAM_CAS_N,
    input  logic        DRAM_WE_N,
    input  logic        DRAM_LDQM,
    input  logic        DRAM_UDQM,
    input  logic        DRAM_CLK,
    input  logic [15:0] dq_in,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    output logic        oinit_done,
    output logic [1:0]  ocas_lat,
    output logic        ocmd_err,
    output logic [7:0]  orefresh_cnt
);

    typedef enum logic [1:0] {WAIT_PRE, WAIT_REF, WAIT_MODE, READY} state_t;

    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_REF = 3'b001;
    localparam logic [2:0] CMD_LMR = 3'b000;

    state_t      state_q, state_d;
    logic        ref_seen_q, ref_seen_d;
    logic [3:0]  open_q, open_d;
    logic [1:0]  cas_q, cas_d;
    logic        err_q, err_d;
    logic [7:0]  ref_cnt_q, ref_cnt_d;
    logic [12:0] row_q [4];
    logic [15:0] mem_q [256];

    logic [2:0]  pv_q;
    logic [2:0]  pcl3_q;
    logic [15:0] pd_q [3];
    logic        out_v_q;
    logic [15:0] out_d_q;

    logic        cmd_vld;
    logic [2:0]  cmd;
    logic        cl_ok;
    logic        row_we, mem_we, rd_go;
    logic [12:0] row_cur;
    logic [7:0]  mem_idx;
    logic [15:0] mem_word, rd_data;
    logic        sel_v;
    logic [15:0] sel_d;
    logic        unused_bits;

    assign cmd_vld  = DRAM_CKE & ~DRAM_CS_N;
    assign cmd      = {DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N};
    assign cl_ok    = (DRAM_ADDR[6:4] == 3'b010) || (DRAM_ADDR[6:4] == 3'b011);
    assign row_cur  = row_q[DRAM_BA];
    assign mem_idx  = {DRAM_BA, row_cur[2:0], DRAM_ADDR[5:3]};
    assign mem_word = mem_q[mem_idx];
    assign rd_data  = {DRAM_UDQM ? 8'h00 : mem_word[15:8], DRAM_LDQM ? 8'h00 : mem_word[7:0]};

    always_comb begin
        state_d    = state_q;
        ref_seen_d = ref_seen_q;
        open_d     = open_q;
        cas_d      = cas_q;
        err_d      = err_q;
        ref_cnt_d  = ref_cnt_q;
        row_we     = 1'b0;
        mem_we     = 1'b0;
        rd_go      = 1'b0;
        if (cmd_vld) begin
            case (cmd)
                CMD_ACT: begin
                    if (state_q != READY || open_q[DRAM_BA]) err_d = 1'b1;
                    else begin
                        open_d[DRAM_BA] = 1'b1;
                        row_we          = 1'b1;
                    end
                end
                CMD_RD: begin
                    if (state_q != READY || !open_q[DRAM_BA]) err_d = 1'b1;
                    else rd_go = 1'b1;
                end
                CMD_WR: begin
                    if (state_q != READY || !open_q[DRAM_BA]) err_d = 1'b1;
                    else mem_we = 1'b1;
                end
                CMD_PRE: begin
                    if (DRAM_ADDR[10]) open_d = 4'b0000;
                    else open_d[DRAM_BA] = 1'b0;
                    if (state_q == WAIT_PRE && DRAM_ADDR[10]) state_d = WAIT_REF;
                end
                CMD_REF: begin
                    if (|open_q) err_d = 1'b1;
                    else begin
                        if (ref_cnt_q != 8'hFF) ref_cnt_d = ref_cnt_q + 8'd1;
                        if (state_q == WAIT_REF) begin
                            if (ref_seen_q) begin
                                state_d    = WAIT_MODE;
                                ref_seen_d = 1'b0;
                            end else begin
                                ref_seen_d = 1'b1;
                            end
                        end
                    end
                end
                CMD_LMR: begin
                    // A rejected mode word changes nothing, not even a valid CAS field.
                    if (state_q == WAIT_PRE || state_q == WAIT_REF ||
                        (state_q == READY && |open_q) || !cl_ok || DRAM_ADDR[2:0] != 3'b000)
                        err_d = 1'b1;
                    else begin
                        cas_d   = DRAM_ADDR[5:4];
                        state_d = READY;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            state_q    <= WAIT_PRE;
            ref_seen_q <= 1'b0;
            open_q     <= 4'b0000;
            cas_q      <= 2'd2;
            err_q      <= 1'b0;
            ref_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            ref_seen_q <= ref_seen_d;
            open_q     <= open_d;
            cas_q      <= cas_d;
            err_q      <= err_d;
            ref_cnt_q  <= ref_cnt_d;
        end
    end

    always_ff @(posedge iclk) begin
        if (row_we && !ireset) row_q[DRAM_BA] <= DRAM_ADDR;
        if (mem_we && !ireset)
            mem_q[mem_idx] <= {DRAM_UDQM ? mem_word[15:8] : dq_in[15:8],
                               DRAM_LDQM ? mem_word[7:0]  : dq_in[7:0]};
    end

    // Each beat carries the latency in force at its READ edge, so a later mode change
    // cannot retime data already in flight.
    always_ff @(posedge iclk) begin
        pd_q[0] <= rd_data;
        pd_q[1] <= pd_q[0];
        pd_q[2] <= pd_q[1];
        pcl3_q  <= {pcl3_q[1:0], cas_q == 2'd3};
    end

    always_comb begin
        sel_v = 1'b0;
        sel_d = 16'h0000;
        if (pv_q[1] && !pcl3_q[1]) begin
            sel_v = 1'b1;
            sel_d = pd_q[1];
        end else if (pv_q[2] && pcl3_q[2]) begin
            sel_v = 1'b1;
            sel_d = pd_q[2];
        end
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            pv_q    <= 3'b000;
            out_v_q <= 1'b0;
            out_d_q <= 16'h0000;
        end else begin
            pv_q    <= {pv_q[1:0], rd_go};
            out_v_q <= sel_v;
            out_d_q <= sel_d;
        end
    end

    assign dq_out       = out_d_q;
    assign dq_oe        = out_v_q;
    assign oinit_done   = (state_q == READY);
    assign ocas_lat     = cas_q;
    assign ocmd_err     = err_q;
    assign orefresh_cnt = ref_cnt_q;

    // Only row[2:0] feeds the storage index; the upper row bits and DRAM_CLK are don't-care.
    assign unused_bits = &{1'b0, DRAM_CLK, row_q[0][12:3], row_q[1][12:3],
                           row_q[2][12:3], row_q[3][12:3]};

endmodule

// File: tb/tb_sdram_responder.sv
// Self-checking bench for sdram_responder: directed vector table, hand-written corner
// sequences and randomized commands, all checked against a cycle-indexed reference model.
module tb_sdram_responder;

    localparam logic [2:0] C_NOP = 3'b111;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_LMR = 3'b000;

    logic        iclk = 1'b0;
    logic        ireset;
    logic [12:0] DRAM_ADDR;
    logic [1:0]  DRAM_BA;
    logic        DRAM_CKE, DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N;
    logic        DRAM_LDQM, DRAM_UDQM;
    logic        DRAM_CLK = 1'b0;
    logic [15:0] dq_in;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic        oinit_done;
    logic [1:0]  ocas_lat;
    logic        ocmd_err;
    logic [7:0]  orefresh_cnt;

    always #5 iclk = ~iclk;
    always #3 DRAM_CLK = ~DRAM_CLK;

    sdram_responder dut (
        .iclk(iclk), .ireset(ireset), .DRAM_ADDR(DRAM_ADDR), .DRAM_BA(DRAM_BA),
        .DRAM_CKE(DRAM_CKE), .DRAM_CS_N(DRAM_CS_N), .DRAM_RAS_N(DRAM_RAS_N),
        .DRAM_CAS_N(DRAM_CAS_N), .DRAM_WE_N(DRAM_WE_N), .DRAM_LDQM(DRAM_LDQM),
        .DRAM_UDQM(DRAM_UDQM), .DRAM_CLK(DRAM_CLK), .dq_in(dq_in), .dq_out(dq_out),
        .dq_oe(dq_oe), .oinit_done(oinit_done), .ocas_lat(ocas_lat), .ocmd_err(ocmd_err),
        .orefresh_cnt(orefresh_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: init phase 0..3 = awaiting precharge-all / refreshes / mode / ready.
    // Read beats are scheduled by the edge number at which they must appear.
    typedef struct {
        logic [15:0] d;
        logic [15:0] k;
    } beat_t;

    int          m_phase = 0, m_refs = 0, m_ref = 0, m_cas = 2;
    bit          m_err = 0;
    bit          m_open[4];
    logic [12:0] m_row[4];
    logic [15:0] m_mem[256];
    bit   [1:0]  m_known[256];
    beat_t       m_sched[int];
    int          cyc = 0;

    function automatic bit any_open();
        return m_open[0] | m_open[1] | m_open[2] | m_open[3];
    endfunction

    task automatic model_edge(input bit rst, input bit vld, input logic [2:0] c,
                              input logic [1:0] ba, input logic [12:0] a,
                              input logic [15:0] d, input bit lm, input bit um);
        int    idx;
        int    cl;
        beat_t b;
        if (rst) begin
            m_phase = 0; m_refs = 0; m_ref = 0; m_cas = 2; m_err = 0;
            foreach (m_open[i]) m_open[i] = 0;
            m_sched.delete();
            return;
        end
        if (!vld) return;
        case (c)
            C_ACT: if (m_phase != 3 || m_open[ba]) m_err = 1;
                   else begin m_open[ba] = 1; m_row[ba] = a; end
            C_RD: begin
                if (m_phase != 3 || !m_open[ba]) m_err = 1;
                else begin
                    idx = ba * 64 + int'(m_row[ba][2:0]) * 8 + int'(a[5:3]);
                    b.d = m_mem[idx];
                    b.k = {{8{m_known[idx][1]}}, {8{m_known[idx][0]}}};
                    if (um) begin b.d[15:8] = 8'h00; b.k[15:8] = 8'hFF; end
                    if (lm) begin b.d[7:0]  = 8'h00; b.k[7:0]  = 8'hFF; end
                    m_sched[cyc + m_cas] = b;
                end
            end
            C_WR: begin
                if (m_phase != 3 || !m_open[ba]) m_err = 1;
                else begin
                    idx = ba * 64 + int'(m_row[ba][2:0]) * 8 + int'(a[5:3]);
                    if (!um) begin m_mem[idx][15:8] = d[15:8]; m_known[idx][1] = 1; end
                    if (!lm) begin m_mem[idx][7:0]  = d[7:0];  m_known[idx][0] = 1; end
                end
            end
            C_PRE: begin
                if (a[10]) begin
                    foreach (m_open[i]) m_open[i] = 0;
                    if (m_phase == 0) m_phase = 1;
                end else m_open[ba] = 0;
            end
            C_REF: begin
                if (any_open()) m_err = 1;
                else begin
                    if (m_ref < 255) m_ref++;
                    if (m_phase == 1) begin
                        m_refs++;
                        if (m_refs == 2) m_phase = 2;
                    end
                end
            end
            C_LMR: begin
                cl = int'(a[6:4]);
                if (m_phase < 2 || (m_phase == 3 && any_open()) || !(cl == 2 || cl == 3) ||
                    a[2:0] != 3'b000) m_err = 1;
                else begin m_cas = cl; m_phase = 3; end
            end
            default: ;
        endcase
    endtask

    task automatic step(input bit rst, input logic [2:0] c, input logic [1:0] ba,
                        input logic [12:0] a, input logic [15:0] d, input bit lm,
                        input bit um, input bit cke, input bit csn);
        beat_t b;
        bit    exp_oe;
        ireset = rst; DRAM_ADDR = a; DRAM_BA = ba; dq_in = d;
        DRAM_CKE = cke; DRAM_CS_N = csn; DRAM_LDQM = lm; DRAM_UDQM = um;
        {DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} = c;
        @(posedge iclk);
        #1;
        cyc++;
        model_edge(rst, cke && !csn, c, ba, a, d, lm, um);
        exp_oe = m_sched.exists(cyc);
        chk("m_dq_oe", dq_oe, exp_oe);
        if (exp_oe) begin
            b = m_sched[cyc];
            chk("m_dq_out", dq_out & b.k, b.d & b.k);
            m_sched.delete(cyc);
        end else begin
            chk("m_dq_idle", dq_out, 0);
        end
        chk("m_init_done", oinit_done, m_phase == 3);
        chk("m_cas_lat", ocas_lat, m_cas);
        chk("m_cmd_err", ocmd_err, m_err);
        chk("m_refresh_cnt", orefresh_cnt, m_ref);
    endtask

    task automatic op(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] a,
                      input logic [15:0] d);
        step(0, c, ba, a, d, 0, 0, 1, 0);
    endtask

    task automatic expect_out(input string t, input bit oe, input logic [15:0] dq,
                              input bit init, input logic [1:0] cas, input bit err,
                              input logic [7:0] rc);
        chk({t, "_oe"}, dq_oe, oe);
        chk({t, "_dq"}, dq_out, dq);
        chk({t, "_init"}, oinit_done, init);
        chk({t, "_cas"}, ocas_lat, cas);
        chk({t, "_err"}, ocmd_err, err);
        chk({t, "_ref"}, orefresh_cnt, rc);
    endtask

    task automatic init_prep();
        step(1, C_NOP, 0, 0, 0, 0, 0, 1, 0);
        op(C_PRE, 0, 13'h400, 0);
        op(C_REF, 0, 0, 0);
        op(C_REF, 0, 0, 0);
    endtask

    typedef struct {
        bit          rst;
        logic [2:0]  c;
        logic [1:0]  ba;
        logic [12:0] a;
        logic [15:0] d;
        bit          lm, um;
        bit          e_oe;
        logic [15:0] e_dq;
        bit          e_init;
        logic [1:0]  e_cas;
        bit          e_err;
        logic [7:0]  e_ref;
    } vec_t;

    function automatic vec_t V(input bit rst, input logic [2:0] c, input logic [1:0] ba,
                               input logic [12:0] a, input logic [15:0] d, input bit lm,
                               input bit um, input bit e_oe, input logic [15:0] e_dq,
                               input bit e_init, input logic [1:0] e_cas,
                               input logic [7:0] e_ref);
        vec_t v;
        v.rst = rst; v.c = c; v.ba = ba; v.a = a; v.d = d; v.lm = lm; v.um = um;
        v.e_oe = e_oe; v.e_dq = e_dq; v.e_init = e_init; v.e_cas = e_cas;
        v.e_err = 1'b0; v.e_ref = e_ref;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  rc;
        logic [1:0]  rba;
        logic [12:0] ra;
        int          w;

        ireset = 1; DRAM_ADDR = 0; DRAM_BA = 0; DRAM_CKE = 1; DRAM_CS_N = 0;
        {DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} = C_NOP; DRAM_LDQM = 0; DRAM_UDQM = 0; dq_in = 0;

        // Init, write/read at CL=2 then CL=3, byte masking.
        tbl.push_back(V(1, C_NOP, 0, 13'h000, 16'h0000, 0, 0, 0, 16'h0000, 0, 2, 0));
        tbl.push_back(V(0, C_PRE, 0, 13'h400, 16'h0000, 0, 0, 0, 16'h0000, 0, 2, 0));
        tbl.push_back(V(0, C_REF, 0, 13'h000, 16'h0000, 0, 0, 0, 16'h0000, 0, 2, 1));
        tbl.push_back(V(0, C_REF, 0, 13'h000, 16'h0000, 0, 0, 0, 16'h0000, 0, 2, 2));
        tbl.push_back(V(0, C_LMR, 0, 13'h020, 16'h0000, 0, 0, 0, 16'h0000, 1, 2, 2));
        tbl.push_back(V(0, C_ACT, 1, 13'h005, 16'h0000, 0, 0, 0, 16'h0000, 1, 2, 2));
        tbl.push_back(V(0, C_WR,  1, 13'h018, 16'hBEEF, 0, 0, 0, 16'h0000, 1, 2, 2));
        tbl.push_back(V(0, C_RD,  1, 13'h018, 16'h0000, 0, 0, 0, 16'h0000, 1, 2, 2));
        tbl.push_back(V(0, C_NOP, 0, 13'h000, 16'h0000, 0, 0, 0, 16'h0000, 1, 2, 2));
        tbl.push_back(V(0, C_NOP, 0, 13'h000, 16'h0000, 0, 0, 1, 16'hBEEF, 1, 2, 2));
        tbl.push_back(V(0, C_NOP, 0, 13'h000, 16'h0000, 0, 0, 0, 16'h0000, 1, 2, 2));
        tbl.push_back(V(0, C_PRE, 1, 13'h000, 16'h0000, 0, 0, 0, 16'h0000, 1, 2, 2));
        tbl.push_back(V(0, C_LMR, 0, 13'h030, 16'h0000, 0, 0, 0, 16'h0000, 1, 3, 2));
        tbl.push_back(V(0, C_ACT, 1, 13'h005, 16'h0000, 0, 0, 0, 16'h0000, 1, 3, 2));
        tbl.push_back(V(0, C_RD,  1, 13'h018, 16'h0000, 0, 0, 0, 16'h0000, 1, 3, 2));
        tbl.push_back(V(0, C_NOP, 0, 13'h000, 16'h0000, 0, 0, 0, 16'h0000, 1, 3, 2));
        tbl.push_back(V(0, C_NOP, 0, 13'h000, 16'h0000, 0, 0, 0, 16'h0000, 1, 3, 2));
        tbl.push_back(V(0, C_NOP, 0, 13'h000, 16'h0000, 0, 0, 1, 16'hBEEF, 1, 3, 2));
        tbl.push_back(V(0, C_NOP, 0, 13'h000, 16'h0000, 0, 0, 0, 16'h0000, 1, 3, 2));
        tbl.push_back(V(0, C_WR,  1, 13'h018, 16'h1234, 0, 0, 0, 16'h0000, 1, 3, 2));
        tbl.push_back(V(0, C_WR,  1, 13'h018, 16'hABCD, 0, 1, 0, 16'h0000, 1, 3, 2));
        tbl.push_back(V(0, C_RD,  1, 13'h018, 16'h0000, 0, 0, 0, 16'h0000, 1, 3, 2));
        tbl.push_back(V(0, C_RD,  1, 13'h018, 16'h0000, 1, 0, 0, 16'h0000, 1, 3, 2));
        tbl.push_back(V(0, C_NOP, 0, 13'h000, 16'h0000, 0, 0, 0, 16'h0000, 1, 3, 2));
        tbl.push_back(V(0, C_NOP, 0, 13'h000, 16'h0000, 0, 0, 1, 16'h12CD, 1, 3, 2));
        tbl.push_back(V(0, C_NOP, 0, 13'h000, 16'h0000, 0, 0, 1, 16'h1200, 1, 3, 2));
        tbl.push_back(V(0, C_NOP, 0, 13'h000, 16'h0000, 0, 0, 0, 16'h0000, 1, 3, 2));

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].c, tbl[i].ba, tbl[i].a, tbl[i].d, tbl[i].lm, tbl[i].um, 1, 0);
            expect_out($sformatf("tbl%0d", i), tbl[i].e_oe, tbl[i].e_dq, tbl[i].e_init,
                       tbl[i].e_cas, tbl[i].e_err, tbl[i].e_ref);
        end

        // READ to a closed bank: error, no beat.
        init_prep();
        op(C_LMR, 0, 13'h020, 0);
        op(C_RD, 2, 13'h018, 0);
        expect_out("rd_closed", 0, 16'h0000, 1, 2, 1, 2);
        for (int i = 0; i < 3; i++) begin
            op(C_NOP, 0, 0, 0);
            chk("rd_closed_nobeat", dq_oe, 0);
        end

        // ACTIVE to an open bank keeps the old row.
        init_prep();
        op(C_LMR, 0, 13'h020, 0);
        op(C_ACT, 0, 13'h001, 0);
        op(C_WR, 0, 13'h000, 16'h5A5A);
        op(C_ACT, 0, 13'h002, 0);
        chk("act_open_err", ocmd_err, 1);
        op(C_RD, 0, 13'h000, 0);
        op(C_NOP, 0, 0, 0);
        op(C_NOP, 0, 0, 0);
        chk("act_open_oe", dq_oe, 1);
        chk("act_open_row_kept", dq_out, 16'h5A5A);

        // LOAD MODE after a single refresh is rejected; init continues afterwards.
        step(1, C_NOP, 0, 0, 0, 0, 0, 1, 0);
        op(C_PRE, 0, 13'h400, 0);
        op(C_REF, 0, 0, 0);
        op(C_LMR, 0, 13'h020, 0);
        expect_out("lmr_early", 0, 16'h0000, 0, 2, 1, 1);
        op(C_REF, 0, 0, 0);
        chk("lmr_early_still_init", oinit_done, 0);
        op(C_LMR, 0, 13'h020, 0);
        chk("lmr_early_then_ready", oinit_done, 1);

        // Bad CAS latency and bad burst length are rejected; LOAD MODE with a bank open too.
        init_prep();
        op(C_LMR, 0, 13'h010, 0);
        expect_out("lmr_badcl", 0, 16'h0000, 0, 2, 1, 2);
        op(C_LMR, 0, 13'h031, 0);
        chk("lmr_badbl_init", oinit_done, 0);
        chk("lmr_badbl_cas", ocas_lat, 2);
        op(C_LMR, 0, 13'h030, 0);
        chk("lmr_good_init", oinit_done, 1);
        chk("lmr_good_cas", ocas_lat, 3);
        op(C_ACT, 0, 13'h000, 0);
        op(C_LMR, 0, 13'h020, 0);
        chk("lmr_open_cas", ocas_lat, 3);

        // Refresh counter saturates at 255.
        op(C_PRE, 0, 13'h400, 0);
        for (int i = 0; i < 260; i++) op(C_REF, 0, 0, 0);
        chk("ref_sat", orefresh_cnt, 255);

        // Four back-to-back READs at CL=2, then the same with reset after the last READ.
        init_prep();
        op(C_LMR, 0, 13'h020, 0);
        op(C_ACT, 2, 13'h003, 0);
        op(C_WR, 2, 13'h000, 16'h1111);
        op(C_WR, 2, 13'h008, 16'h2222);
        op(C_WR, 2, 13'h010, 16'h3333);
        op(C_WR, 2, 13'h018, 16'h4444);
        op(C_RD, 2, 13'h000, 0);
        op(C_RD, 2, 13'h008, 0);
        op(C_RD, 2, 13'h010, 0);
        chk("pipe_b0", dq_out, 16'h1111);
        op(C_RD, 2, 13'h018, 0);
        chk("pipe_b1", dq_out, 16'h2222);
        op(C_NOP, 0, 0, 0);
        chk("pipe_b2", dq_out, 16'h3333);
        op(C_NOP, 0, 0, 0);
        chk("pipe_b3", dq_out, 16'h4444);
        chk("pipe_b3_oe", dq_oe, 1);
        op(C_NOP, 0, 0, 0);
        chk("pipe_end_oe", dq_oe, 0);

        op(C_RD, 2, 13'h000, 0);
        op(C_RD, 2, 13'h008, 0);
        op(C_RD, 2, 13'h010, 0);
        chk("rstpipe_b0", dq_out, 16'h1111);
        op(C_RD, 2, 13'h018, 0);
        chk("rstpipe_b1", dq_out, 16'h2222);
        step(1, C_NOP, 0, 0, 0, 0, 0, 1, 0);
        expect_out("rstpipe_rst", 0, 16'h0000, 0, 2, 0, 0);
        op(C_NOP, 0, 0, 0);
        chk("rstpipe_sup", dq_oe, 0);
        op(C_PRE, 0, 13'h400, 0);
        op(C_REF, 0, 0, 0);
        op(C_REF, 0, 0, 0);
        op(C_LMR, 0, 13'h020, 0);
        op(C_ACT, 2, 13'h003, 0);
        op(C_RD, 2, 13'h010, 0);
        op(C_NOP, 0, 0, 0);
        op(C_NOP, 0, 0, 0);
        chk("rstpipe_retained_oe", dq_oe, 1);
        chk("rstpipe_retained", dq_out, 16'h3333);

        // Randomized commands against the reference model.
        for (int r = 0; r < 6; r++) begin
            init_prep();
            op(C_LMR, 0, (r % 2 == 1) ? 13'h030 : 13'h020, 0);
            for (int n = 0; n < 150; n++) begin
                ra  = 13'($urandom);
                rba = 2'($urandom);
                w   = $urandom_range(0, 99);
                if (m_phase != 3 && $urandom_range(0, 9) < 7) begin
                    rc = (m_phase == 0) ? C_PRE : (m_phase == 1) ? C_REF : C_LMR;
                    ra = (m_phase == 0) ? 13'h400 : 13'h020;
                end else if (w < 10) rc = C_NOP;
                else if (w < 30) rc = C_ACT;
                else if (w < 55) rc = C_RD;
                else if (w < 80) rc = C_WR;
                else if (w < 90) rc = C_PRE;
                else if (w < 95) rc = C_REF;
                else rc = C_LMR;
                if ((rc == C_RD || rc == C_WR) && any_open() && $urandom_range(0, 9) < 8)
                    while (!m_open[rba]) rba = 2'($urandom);
                if (rc == C_PRE) ra[10] = ($urandom_range(0, 9) < 3);
                if (rc == C_LMR && m_phase == 3) begin
                    ra = 13'h000;
                    ra[6:4] = ($urandom_range(0, 9) == 0) ? 3'($urandom) :
                              ($urandom_range(0, 1) == 1) ? 3'b011 : 3'b010;
                    ra[2:0] = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b000;
                end
                step($urandom_range(0, 99) == 0, rc, rba, ra, 16'($urandom),
                     $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                     $urandom_range(0, 19) != 0, $urandom_range(0, 19) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sdram_responder.md
SDRAM_RESPONDER -- requirements
Module: sdram_responder

Interface
REQ-001 The block SHALL have the ports listed in REQ-002 to REQ-015: one clock, reset synchronous and active-high, all other inputs sampled on the rising edge of iclk.
REQ-002 iclk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 ireset  in  1  synchronous active-high reset.
REQ-004 DRAM_ADDR  in  13  row address (ACTIVE), column address (READ/WRITE), A10 all-banks flag (PRECHARGE), mode word (LOAD MODE).
REQ-005 DRAM_BA  in  2  bank select.
REQ-006 DRAM_CKE, DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N  in  1 each  command pins.
REQ-007 DRAM_LDQM, DRAM_UDQM  in  1 each  byte masks: LDQM for [7:0], UDQM for [15:8]; 1 = masked.
REQ-008 DRAM_CLK  in  1  SHALL be ignored; the block runs on iclk only.
REQ-009 dq_in  in  16  write data from the controller.
REQ-010 dq_out  out  16  read data.
REQ-011 dq_oe  out  1  dq_out valid strobe.
REQ-012 oinit_done  out  1  initialization sequence complete.
REQ-013 ocas_lat  out  2  programmed CAS latency (2 or 3).
REQ-014 ocmd_err  out  1  sticky protocol-violation flag.
REQ-015 orefresh_cnt  out  8  AUTO REFRESH count, saturating at 255.

Function
REQ-016 Commands SHALL be decoded only when CKE=1 and CS_N=0; otherwise the cycle is a NOP. {RAS_N,CAS_N,WE_N} SHALL decode as: 111 NOP, 011 ACTIVE, 101 READ, 100 WRITE, 010 PRECHARGE, 001 AUTO REFRESH, 000 LOAD MODE, 110 BURST TERMINATE (treated as NOP).
REQ-017 Init FSM states SHALL be WAIT_PRE -> WAIT_REF -> WAIT_MODE -> READY.
  - WAIT_PRE -> WAIT_REF on PRECHARGE with A10=1.
  - WAIT_REF -> WAIT_MODE after the second AUTO REFRESH.
  - WAIT_MODE -> READY on LOAD MODE.
  - oinit_done=1 only in READY.
REQ-018 During init, LOAD MODE before two refreshes, and any ACTIVE, READ or WRITE, SHALL set ocmd_err without changing FSM state.
REQ-019 On LOAD MODE, the block SHALL check A[6:4] and A[2:0]:
  - CAS latency A[6:4] of 010 or 011 SHALL be latched into ocas_lat.
  - Any other latency SHALL set ocmd_err and leave ocas_lat unchanged.
  - Burst length A[2:0] other than 000 SHALL set ocmd_err.
  - LOAD MODE in READY while any bank is open SHALL set ocmd_err and SHALL be ignored.
REQ-020 Each bank SHALL hold an open flag and a 13-bit row register.
  - ACTIVE to a closed bank SHALL open it with the given row.
  - ACTIVE to an open bank SHALL set ocmd_err and keep the old row.
  - PRECHARGE SHALL close BA, or all banks if A10=1.
  - AUTO REFRESH with any bank open SHALL set ocmd_err.
REQ-021 Storage SHALL be 256x16. The index is {BA[1:0], open_row[2:0], col[5:3]}; the remaining address bits SHALL alias.
REQ-022 WRITE to an open bank SHALL store dq_in on the same edge as the command. Masked bytes SHALL keep their old value.
REQ-023 WRITE or READ to a closed bank SHALL set ocmd_err and SHALL NOT touch storage or output data.
REQ-024 READ to an open bank SHALL give dq_oe=1 for exactly one cycle, ocas_lat cycles after the READ edge.
  - CL=2: the READ is sampled at edge N and dq_oe is high in the cycle after edge N+2.
  - Bytes masked at the READ edge SHALL be driven 0.
REQ-025 Read data SHALL pass through a 3-deep shift pipeline. Back-to-back READs on consecutive cycles SHALL each produce one data beat in order, with no gaps.
REQ-026 A WRITE to the same address while a READ of it is in flight SHALL NOT change the in-flight data; read data is captured at the READ edge.
REQ-027 When dq_oe=0, dq_out SHALL be 0.
REQ-028 orefresh_cnt SHALL increment on every AUTO REFRESH, including refreshes during init, and SHALL hold at 255.
REQ-029 ocmd_err SHALL be sticky until reset.
REQ-030 Simultaneous error and valid action within one command SHALL NOT occur: an erroneous command SHALL have no side effect other than ocmd_err.

Reset
REQ-031 With ireset=1 at an edge, on that edge:
  - The init FSM SHALL go to WAIT_PRE and all banks SHALL close.
  - The read pipeline SHALL be flushed.
  - dq_out=0, dq_oe=0, oinit_done=0, ocas_lat=2'd2, ocmd_err=0, orefresh_cnt=0.
  - Storage contents SHALL NOT be reset.
REQ-032 Reset during a pending READ SHALL suppress its data beat.

Verification
REQ-033 Init: PRECHARGE A10=1, two AUTO REFRESH, LOAD MODE A=0x020 -> oinit_done=1, ocas_lat=2, orefresh_cnt=2, ocmd_err=0.
REQ-034 Write/read: ACTIVE BA=1 row=0x005, WRITE col=0x018 data=0xBEEF, READ same -> dq_oe one cycle at CL=2 with dq_out=0xBEEF; repeat with CL=3 -> latency 3.
REQ-035 Masking: write 0x1234 then WRITE 0xABCD with UDQM=1 -> reads back 0x12CD; READ with LDQM=1 -> dq_out=0x1200.
REQ-036 Errors: READ to closed bank; ACTIVE to open bank; LOAD MODE after a single refresh; LOAD MODE with A[6:4]=001 -> each sets ocmd_err, with no data beat and no state change.
REQ-037 Pipeline and reset: four consecutive READs -> four consecutive beats in order; assert ireset one cycle after the last READ -> the remaining beats are suppressed, all outputs are at reset values, and data written before reset is still readable after re-init.
